// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback register-file write path.
package wb_pkg;
  localparam int REG_ADDR_W       = 5;
  localparam int DATA_W           = 32;
  localparam int DEF_DEPTH        = 4;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wr_entry_t;
endpackage

// File: rtl/wr_fifo.sv
// Circular buffer of deferred MDU writes; slots are exposed so the owner can squash and scan them.
module wr_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  wr_entry_t             push_entry,
  input  logic                  pop,
  input  logic [DEPTH-1:0]      inval,
  output wr_entry_t             head,
  output wr_entry_t [DEPTH-1:0] slots,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (inval[i]) slots[i].valid <= 1'b0;
      // Popped slots drop their valid bit so stale data never shows in the scan.
      if (pop) begin
        slots[rptr].valid <= 1'b0;
        rptr              <= rptr + 1'b1;
      end
      // Push lands last: a same-cycle push into the popped slot wins.
      if (push) begin
        slots[wptr] <= push_entry;
        wptr        <= wptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = slots[rptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/regfile_write_arbiter.sv
// Single RF write port shared by the in-order pipeline (priority) and a buffered MDU result stream.
module regfile_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0]     ResultW,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  md_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0]     rf_wd,
  output logic [31:0]           pending_mask,
  output logic                  stall_req
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                  full, empty, pop, push, bypass;
  logic                  sel_we;
  logic [REG_ADDR_W-1:0] sel_wa;
  logic [DATA_W-1:0]     sel_wd;
  logic [DEPTH-1:0]      inval;
  logic [SW-1:0]         starve_cnt;
  wr_entry_t             head, push_entry;
  wr_entry_t [DEPTH-1:0] slots;

  always_comb begin
    pop      = reset_n && !RegWriteW && !empty;
    bypass   = reset_n && !RegWriteW && empty && md_valid;
    md_ready = reset_n && (!full || pop);
    push     = md_valid && md_ready && !bypass;
    push_entry = '{valid: 1'b1, rd: md_reg, data: md_data};
  end

  // A newer pipeline write kills older buffered writes to the same register.
  always_comb begin
    inval = '0;
    for (int i = 0; i < DEPTH; i++)
      inval[i] = reset_n && RegWriteW && (WriteRegW != '0) && (slots[i].rd == WriteRegW);
  end

  wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .inval      (inval),
    .head       (head),
    .slots      (slots),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (slots[i].valid) pending_mask[slots[i].rd] = 1'b1;
    pending_mask[0] = 1'b0;
    if (!reset_n) pending_mask = '0;
  end

  always_comb begin
    sel_we = 1'b0;
    sel_wa = '0;
    sel_wd = '0;
    if (RegWriteW) begin
      sel_we = 1'b1;
      sel_wa = WriteRegW;
      sel_wd = ResultW;
    end else if (!empty) begin
      sel_we = head.valid;
      sel_wa = head.rd;
      sel_wd = head.data;
    end else if (md_valid) begin
      sel_we = 1'b1;
      sel_wa = md_reg;
      sel_wd = md_data;
    end
    rf_we = reset_n && sel_we && (sel_wa != '0);
    rf_wa = rf_we ? sel_wa : '0;
    rf_wd = rf_we ? sel_wd : '0;
  end

  // Counts pipeline cycles that keep a non-empty buffer from draining.
  always_ff @(posedge clk) begin
    if (!reset_n)                          starve_cnt <= '0;
    else if (pop || empty)                 starve_cnt <= '0;
    else if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end

  assign stall_req = reset_n && (starve_cnt == SW'(STARVE_LIMIT));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed test-plan steps plus randomized traffic, checked against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset_n, RegWriteW, md_valid;
  logic [4:0]  WriteRegW, md_reg;
  logic [31:0] ResultW, md_data;
  logic        md_ready, rf_we, stall_req;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, pending_mask;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pending_mask(pending_mask), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit [4:0] r; bit [31:0] d; } ent_t;
  ent_t        q[$];
  int          starve;
  int          nchecks = 0, nerr = 0;
  bit          m_pop, m_push;
  logic        e_we, e_rdy, e_stall;
  logic [4:0]  e_wa;
  logic [31:0] e_wd, e_mask;
  logic [31:0] shadow_rf [32];
  logic        cap_we;
  logic [4:0]  cap_wa;
  logic [31:0] cap_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    int n;
    bit byp;
    n = q.size();
    {e_we, e_wa, e_wd, e_rdy, e_mask, e_stall, m_pop, m_push} = '0;
    if (!reset_n) return;
    m_pop  = !RegWriteW && n > 0;
    byp    = !RegWriteW && n == 0 && md_valid;
    e_rdy  = (n < DEPTH) || m_pop;
    m_push = md_valid && e_rdy && !byp;
    if (RegWriteW) begin
      e_we = (WriteRegW != 0); e_wa = WriteRegW; e_wd = ResultW;
    end else if (n > 0) begin
      e_we = q[0].v && q[0].r != 0; e_wa = q[0].r; e_wd = q[0].d;
    end else if (md_valid) begin
      e_we = (md_reg != 0); e_wa = md_reg; e_wd = md_data;
    end
    if (!e_we) begin e_wa = 0; e_wd = 0; end
    foreach (q[i]) if (q[i].v && q[i].r != 0) e_mask[q[i].r] = 1'b1;
    e_stall = (starve == LIMIT);
  endtask

  task automatic model_clock();
    bit was_empty;
    ent_t e;
    if (!reset_n) begin q.delete(); starve = 0; return; end
    was_empty = (q.size() == 0);
    if (RegWriteW && WriteRegW != 0)
      foreach (q[i]) if (q[i].r == WriteRegW) q[i].v = 0;
    if (m_pop) void'(q.pop_front());
    if (m_push) begin e.v = 1; e.r = md_reg; e.d = md_data; q.push_back(e); end
    if (m_pop || was_empty) starve = 0;
    else if (RegWriteW && starve < LIMIT) starve++;
  endtask

  // Drive at the falling edge, compare 1ns later against the model.
  task automatic step(input logic rst, input logic rw, input logic [4:0] wr, input logic [31:0] res,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md);
    reset_n = rst; RegWriteW = rw; WriteRegW = wr; ResultW = res;
    md_valid = mv; md_reg = mr; md_data = md;
    #1;
    model_eval();
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_wa", 32'(rf_wa), 32'(e_wa));
    chk("rf_wd", rf_wd, e_wd);
    chk("md_ready", 32'(md_ready), 32'(e_rdy));
    chk("pending_mask", pending_mask, e_mask);
    chk("stall_req", 32'(stall_req), 32'(e_stall));
    cap_we = rf_we; cap_wa = rf_wa; cap_wd = rf_wd;
  endtask

  task automatic tick();
    @(posedge clk);
    if (cap_we === 1'b1) shadow_rf[cap_wa] = cap_wd;
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    starve = 0;
    foreach (shadow_rf[i]) shadow_rf[i] = '0;
    @(negedge clk);

    // Reset state, with the MDU offering a result
    step(0, 0, 0, 0, 1, 5, 32'h55);
    chk("reset_md_ready", 32'(md_ready), 0);
    chk("reset_rf_we", 32'(rf_we), 0);
    tick();

    // Pipeline-only write
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    chk("pipe_wa", 32'(rf_wa), 5);
    chk("pipe_wd", rf_wd, 32'hDEADBEEF);
    chk("pipe_mask", pending_mask, 0);
    tick();

    // Bypass, then buffer behind a pipeline write
    step(1, 0, 0, 0, 1, 9, 32'h10);
    chk("bypass_wa", 32'(rf_wa), 9);
    tick();
    step(1, 1, 3, 32'h33, 1, 10, 32'h20);
    chk("buf_pipe_wa", 32'(rf_wa), 3);
    tick();
    idle();
    chk("buf_mask", pending_mask, 32'h400);
    chk("buf_drain_wa", 32'(rf_wa), 10);
    tick();
    idle();
    chk("buf_mask_clear", pending_mask, 0);
    tick();

    // Fill to full while the pipeline hogs the port
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 1, 32'(k), 1, 5'(11 + k), 32'h100 + 32'(k));
      chk("fill_ready", 32'(md_ready), (k < 4) ? 1 : 0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("drain_order", 32'(rf_wa), 32'(11 + k));
      tick();
    end
    idle();
    chk("drain_done", 32'(rf_we), 0);
    tick();

    // WAW squash
    step(1, 1, 1, 0, 1, 7, 32'h1);
    tick();
    step(1, 1, 7, 32'h2, 0, 0, 0);
    chk("waw_mask_before", pending_mask, 32'h80);
    tick();
    idle();
    chk("waw_mask_after", pending_mask, 0);
    chk("waw_squashed_we", 32'(rf_we), 0);
    tick();
    chk("waw_r7_final", shadow_rf[7], 32'h2);

    // Starvation
    step(1, 1, 1, 0, 1, 4, 32'h44);
    tick();
    for (int k = 0; k < LIMIT; k++) begin
      step(1, 1, 2, 32'(k), 0, 0, 0);
      chk("starve_no_stall", 32'(stall_req), 0);
      tick();
    end
    idle();
    chk("starve_stall", 32'(stall_req), 1);
    chk("starve_drain_wa", 32'(rf_wa), 4);
    tick();
    idle();
    chk("starve_release", 32'(stall_req), 0);
    tick();

    // Reset with three buffered entries
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1, 0, 1, 5'(20 + k), 32'(k));
      tick();
    end
    step(0, 0, 0, 0, 1, 6, 32'h6);
    chk("rst_mid_mask", pending_mask, 0);
    chk("rst_mid_ready", 32'(md_ready), 0);
    chk("rst_mid_we", 32'(rf_we), 0);
    tick();
    idle();
    chk("post_rst_ready", 32'(md_ready), 1);
    chk("post_rst_we", 32'(rf_we), 0);
    tick();

    // Randomized traffic with a narrow register range to provoke WAW hits
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)),
           $urandom, ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
